rot_step_controller: RTL and testbench
======================================

Name: rot_step_controller

Overview:
- Control FSM for the rotation (rho) step unit of the encoder.
- Performs the unit-side handshake with the encoder controller: `ready`, `start`, `putInput`, `outReady`.
- Sequences slice capture, per-lane iterative rotation and slice unload in the rotation datapath.
- The datapath rotates one selected lane by one bit position per enabled cycle; this block decides how many cycles and which lane.

Parameters:
- NUM_SLICES, 64, slices per state word; length of the load and unload windows.
- SLICE_W, 6, width of the slice counter, clog2(NUM_SLICES).
- LANES, 25, number of lanes rotated per pass.
- LANE_W, 5, width of `laneIdx`.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one rotation pass; sampled only in Idle.
- rotOffset  in  SLICE_W  rotation amount for lane `laneIdx`, from the datapath offset ROM; valid one cycle after `laneIdx` changes.
- ready  out  1  unit idle, accepting `start`.
- putInput  out  1  one-cycle pulse: input slices follow next cycle.
- outReady  out  1  one-cycle pulse: output slices follow next cycle.
- loadEn  out  1  datapath captures the input slice this cycle.
- rotEn  out  1  datapath rotates lane `laneIdx` by one position this cycle.
- outEn  out  1  datapath drives the output slice this cycle.
- laneIdx  out  LANE_W  selected lane and offset ROM address.
- busy  out  1  high whenever the state is not Idle.

Behaviour:
- Reset: synchronous, active-high. Any cycle with rst=1 forces Idle at the next edge and clears `sliceCnt`, `laneIdx`, `rotCnt` and `offReg`, including mid-pass. Reset outputs: ready=1, busy=0, laneIdx=0; all others 0.
- Outputs are Moore, decoded from the state. `laneIdx` is a register.
- Internal registers: `sliceCnt`[SLICE_W], `rotCnt`[SLICE_W], `offReg`[SLICE_W].
- States and transitions:
  - Idle: ready=1. start → Init; otherwise stay. `start` is ignored in every other state.
  - Init: clear `sliceCnt`, `laneIdx` and `rotCnt` → PutIn.
  - PutIn: putInput=1 → Load.
  - Load: loadEn=1, `sliceCnt`++. When `sliceCnt`==NUM_SLICES-1 this cycle → LaneFetch (exactly NUM_SLICES load cycles). `sliceCnt` wraps to 0.
  - LaneFetch: `offReg` ← rotOffset, `rotCnt` ← 0. If rotOffset==0 → LaneNext, else → Rotate.
  - Rotate: rotEn=1, `rotCnt`++. When `rotCnt`==`offReg`-1 → LaneNext (exactly `offReg` rotate cycles). Changes on `rotOffset` during Rotate have no effect.
  - LaneNext: if `laneIdx`==LANES-1 → Inform with `laneIdx` ← 0; else `laneIdx`++ → LaneFetch.
  - Inform: outReady=1, `sliceCnt` ← 0 → Unload.
  - Unload: outEn=1, `sliceCnt`++. When `sliceCnt`==NUM_SLICES-1 → Idle (exactly NUM_SLICES unload cycles).
- Cycle timing (cycle 1 = first cycle after the edge that samples start=1 in Idle):
  - Init: cycle 1; PutIn: cycle 2; Load: cycles 3..NUM_SLICES+2.
  - Rotation phase: 2 cycles per lane plus the sum of all lane offsets.
  - Inform follows the rotation phase, then NUM_SLICES Unload cycles, then Idle.
- Maximum offset is NUM_SLICES-1; no modular reduction is needed because of the width.
- At most one of loadEn, rotEn, outEn, putInput, outReady is high in any cycle.
- `start` held high through a whole pass: a new pass begins on the first Idle cycle after return; ready is high for at least one cycle between passes.

Test Plan:
- Reset: assert rst for 2 cycles mid-Rotate → next cycle ready=1, busy=0, laneIdx=0, every enable 0; no further rotEn pulses.
- All offsets 0, NUM_SLICES=64: start at cycle 0 →
  - putInput high in cycle 2 only;
  - loadEn high in cycles 3..66 (64 cycles);
  - rotEn never high;
  - outReady in cycle 117;
  - outEn in cycles 118..181;
  - ready high again in cycle 182.
- All offsets 1: exactly 25 rotEn cycles, each with a distinct laneIdx 0..24 in order; outReady in cycle 142.
- Standard Keccak rho offsets (0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14) → per-lane rotEn counts match the table; 680 rotEn cycles in total; outReady in cycle 797.
- rotOffset changed from 5 to 60 during lane 3's Rotate → lane 3 still gets exactly 5 rotEn cycles.
- start pulsed during Load and during Unload → ignored, no extra putInput; start asserted continuously → back-to-back passes separated by exactly one ready cycle.

Source files
------------

// File: rtl/rot_step_controller.sv
// Control FSM for the rho rotation unit: encoder handshake, slice load/unload
// windows, and per-lane iterative rotation (one bit position per rotEn cycle).
module rot_step_controller #(
  parameter int NUM_SLICES = 64,
  parameter int SLICE_W    = 6,
  parameter int LANES      = 25,
  parameter int LANE_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SLICE_W-1:0] rotOffset,
  output logic               ready,
  output logic               putInput,
  output logic               outReady,
  output logic               loadEn,
  output logic               rotEn,
  output logic               outEn,
  output logic [LANE_W-1:0]  laneIdx,
  output logic               busy
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_PUTIN  = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_FETCH  = 4'd4;
  localparam logic [3:0] S_ROTATE = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_INFORM = 4'd7;
  localparam logic [3:0] S_UNLOAD = 4'd8;

  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NUM_SLICES - 1);
  localparam logic [LANE_W-1:0]  LANE_LAST  = LANE_W'(LANES - 1);

  logic [3:0]         state_q, state_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [SLICE_W-1:0] rot_cnt_q, rot_cnt_d;
  logic [SLICE_W-1:0] off_q, off_d;
  logic [LANE_W-1:0]  lane_idx_q, lane_idx_d;

  always_comb begin
    state_d     = state_q;
    slice_cnt_d = slice_cnt_q;
    rot_cnt_d   = rot_cnt_q;
    off_d       = off_q;
    lane_idx_d  = lane_idx_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT: begin
        slice_cnt_d = '0;
        rot_cnt_d   = '0;
        lane_idx_d  = '0;
        state_d     = S_PUTIN;
      end
      S_PUTIN: state_d = S_LOAD;
      S_LOAD: begin
        slice_cnt_d = slice_cnt_q + SLICE_W'(1);
        if (slice_cnt_q == SLICE_LAST) state_d = S_FETCH;
      end
      // Offset is latched here so later ROM-side changes cannot stretch the lane.
      S_FETCH: begin
        off_d     = rotOffset;
        rot_cnt_d = '0;
        state_d   = (rotOffset == '0) ? S_NEXT : S_ROTATE;
      end
      S_ROTATE: begin
        rot_cnt_d = rot_cnt_q + SLICE_W'(1);
        if (rot_cnt_q == off_q - SLICE_W'(1)) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (lane_idx_q == LANE_LAST) begin
          lane_idx_d = '0;
          state_d    = S_INFORM;
        end else begin
          lane_idx_d = lane_idx_q + LANE_W'(1);
          state_d    = S_FETCH;
        end
      end
      S_INFORM: begin
        slice_cnt_d = '0;
        state_d     = S_UNLOAD;
      end
      S_UNLOAD: begin
        slice_cnt_d = slice_cnt_q + SLICE_W'(1);
        if (slice_cnt_q == SLICE_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slice_cnt_q <= '0;
      rot_cnt_q   <= '0;
      off_q       <= '0;
      lane_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      slice_cnt_q <= slice_cnt_d;
      rot_cnt_q   <= rot_cnt_d;
      off_q       <= off_d;
      lane_idx_q  <= lane_idx_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign putInput = (state_q == S_PUTIN);
  assign loadEn   = (state_q == S_LOAD);
  assign rotEn    = (state_q == S_ROTATE);
  assign outReady = (state_q == S_INFORM);
  assign outEn    = (state_q == S_UNLOAD);
  assign laneIdx  = lane_idx_q;

endmodule

// File: tb/tb_rot_step_controller.sv
// Bench for rot_step_controller: a per-pass expected output timeline is built
// from lane offsets and compared every cycle, plus literal timing anchors.
module tb_rot_step_controller;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [5:0] rotOffset;
  logic       ready, putInput, outReady, loadEn, rotEn, outEn, busy;
  logic [4:0] laneIdx;

  rot_step_controller dut (
    .clk(clk), .rst(rst), .start(start), .rotOffset(rotOffset),
    .ready(ready), .putInput(putInput), .outReady(outReady), .loadEn(loadEn),
    .rotEn(rotEn), .outEn(outEn), .laneIdx(laneIdx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Offset ROM seen by the DUT; ovr replaces lane 3's offset while it rotates.
  int rom [25];
  logic ovr = 1'b0;
  assign rotOffset = (ovr && rotEn && laneIdx == 5'd3) ? 6'd60 : 6'(rom[laneIdx]);

  // Output vector: {ready,busy,putInput,outReady,loadEn,rotEn,outEn,laneIdx}
  typedef logic [11:0] vec_t;
  vec_t q[$];

  function automatic vec_t mk(input logic [6:0] f, input int lane);
    return {f, 5'(lane)};
  endfunction

  localparam logic [6:0] F_IDLE = 7'b1000000, F_BUSY = 7'b0100000,
                         F_PUT  = 7'b0110000, F_INF  = 7'b0101000,
                         F_LOAD = 7'b0100100, F_ROT  = 7'b0100010,
                         F_OUT  = 7'b0100001;

  task automatic build_pass();
    q.push_back(mk(F_BUSY, 0));
    q.push_back(mk(F_PUT, 0));
    for (int i = 0; i < 64; i++) q.push_back(mk(F_LOAD, 0));
    for (int l = 0; l < 25; l++) begin
      q.push_back(mk(F_BUSY, l));
      for (int r = 0; r < rom[l]; r++) q.push_back(mk(F_ROT, l));
      q.push_back(mk(F_BUSY, l));
    end
    q.push_back(mk(F_INF, 0));
    for (int i = 0; i < 64; i++) q.push_back(mk(F_OUT, 0));
  endtask

  // Per-pass observations, indexed from cycle 1 = Init.
  int cyc, active, put_cyc, load_first, load_n, inf_cyc, out_first, out_n, rdy_cyc, rot_tot;
  int lane_rot [25];
  int rdy_run = 0, last_rdy_run = 0;

  always @(posedge clk) begin
    vec_t exp_v, act_v;
    logic accepted;
    accepted = 1'b0;
    if (rst) q.delete();
    else if (q.size() == 0) begin
      if (start) begin build_pass(); accepted = 1'b1; end
    end else void'(q.pop_front());
    #1;
    exp_v = (q.size() != 0) ? q[0] : mk(F_IDLE, 0);
    act_v = {ready, busy, putInput, outReady, loadEn, rotEn, outEn, laneIdx};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, act_v, exp_v);
    end
    if (ready) rdy_run++;
    else if (rdy_run > 0) begin last_rdy_run = rdy_run; rdy_run = 0; end
    if (rst) active = 0;
    else if (accepted) begin
      active = 1; cyc = 1; put_cyc = 0; load_first = 0; load_n = 0; inf_cyc = 0;
      out_first = 0; out_n = 0; rdy_cyc = 0; rot_tot = 0;
      foreach (lane_rot[i]) lane_rot[i] = 0;
    end else if (active != 0) cyc++;
    if (active != 0) begin
      if (putInput) put_cyc = cyc;
      if (loadEn) begin if (load_n == 0) load_first = cyc; load_n++; end
      if (rotEn) begin rot_tot++; lane_rot[laneIdx]++; end
      if (outReady) inf_cyc = cyc;
      if (outEn) begin if (out_n == 0) out_first = cyc; out_n++; end
      if (ready) begin rdy_cyc = cyc; active = 0; end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Pulse start, then wait (bounded) for ready; rnd sprinkles start pulses mid-pass.
  task automatic run_pass(input bit rnd);
    bit done;
    done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      start = (rnd && !ready) ? ($urandom_range(0, 5) == 0) : 1'b0;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL pass_timeout got=busy want=ready");
    end
  endtask

  int keccak [25] = '{0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14};

  initial begin
    rst = 1'b1; start = 1'b0;
    foreach (rom[i]) rom[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_lane", laneIdx, 0);
    rst = 1'b0;
    @(negedge clk);

    // All offsets zero: timeline anchors.
    run_pass(1'b0);
    chk("z_putinput", put_cyc, 2);
    chk("z_load_first", load_first, 3);
    chk("z_load_n", load_n, 64);
    chk("z_rot_total", rot_tot, 0);
    chk("z_outready", inf_cyc, 117);
    chk("z_out_first", out_first, 118);
    chk("z_out_n", out_n, 64);
    chk("z_ready_back", rdy_cyc, 182);

    // All offsets one.
    foreach (rom[i]) rom[i] = 1;
    run_pass(1'b0);
    chk("one_rot_total", rot_tot, 25);
    for (int l = 0; l < 25; l++) chk($sformatf("one_lane%0d", l), lane_rot[l], 1);
    chk("one_outready", inf_cyc, 142);

    // Keccak rho table, with stray start pulses during the pass.
    foreach (rom[i]) rom[i] = keccak[i];
    run_pass(1'b1);
    for (int l = 0; l < 25; l++) chk($sformatf("rho_lane%0d", l), lane_rot[l], keccak[l]);
    chk("rho_rot_total", rot_tot, 680);
    chk("rho_outready", inf_cyc, 797);
    chk("rho_putinput", put_cyc, 2);

    // Offset changes during lane 3's rotation must not matter.
    foreach (rom[i]) rom[i] = 2;
    rom[3] = 5; ovr = 1'b1;
    run_pass(1'b0);
    ovr = 1'b0;
    chk("ovr_lane3", lane_rot[3], 5);

    // Random offsets with random start noise.
    for (int p = 0; p < 4; p++) begin
      int sum;
      sum = 0;
      foreach (rom[i]) begin rom[i] = $urandom_range(0, 63); sum += rom[i]; end
      run_pass(1'b1);
      chk("rnd_rot_total", rot_tot, sum);
      chk("rnd_outready", inf_cyc, 67 + 50 + sum);
    end

    // Start held high: back-to-back passes with exactly one ready cycle between.
    foreach (rom[i]) rom[i] = 1;
    start = 1'b1;
    for (int i = 0; i < 420; i++) @(negedge clk);
    start = 1'b0;
    chk("b2b_ready_gap", last_rdy_run, 1);
    for (int i = 0; i < 300 && !ready; i++) @(negedge clk);

    // Reset mid-Rotate.
    foreach (rom[i]) rom[i] = 10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && !rotEn; i++) @(negedge clk);
    chk("pre_reset_rot", rotEn, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_lane", laneIdx, 0);
    chk("rst_mid_en", {putInput, outReady, loadEn, rotEn, outEn}, 0);
    repeat (40) @(negedge clk);
    chk("rst_stays_idle", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
